// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard control: forwarding, load-use stall, branch flush, memory-wait hold.
// Outputs combinational (zero latency); a not-ready M-stage access holds F/D/E/M until ready or timeout.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Match_1E_M,
  input  logic          Match_1E_W,
  input  logic          Match_2E_M,
  input  logic          Match_2E_W,
  input  logic          Match_12D_E,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          MemtoRegE,
  input  logic          PCSrcD,
  input  logic          PCSrcE,
  input  logic          PCSrcM,
  input  logic          PCSrcW,
  input  logic          BranchTakenE,
  input  logic          MemReqM,
  input  logic          MemReadyM,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          StallM,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushW,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          FlagWrEnE,
  output logic          MemTimeout,
  output logic [CW-1:0] StallCount
);

  typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nxt;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic          ldrstall, pc_wr_pending, memstall;

  assign ldrstall      = Match_12D_E & MemtoRegE;
  assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;
  assign memstall      = MemReqM & ~MemReadyM & (state != ABORT);

  // M stage holds the newer value, so it wins over W
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (Match_1E_M && RegWriteM)      ForwardAE = 2'b10;
    else if (Match_1E_W && RegWriteW) ForwardAE = 2'b01;
    if (Match_2E_M && RegWriteM)      ForwardBE = 2'b10;
    else if (Match_2E_W && RegWriteW) ForwardBE = 2'b01;
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: begin
        if (memstall) begin
          state_nxt = WAIT;
          wcnt_nxt  = WW'(1);
        end
      end
      WAIT: begin
        // a dropped request counts as completed
        if (MemReadyM || !MemReqM) begin
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end else if (wcnt == WW'(TIMEOUT - 1)) begin
          state_nxt = ABORT;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt = wcnt + WW'(1);
        end
      end
      ABORT: begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memstall) begin
      // whole pipe frozen; branch and load-use actions wait until memory resolves
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldrstall | pc_wr_pending;
      StallD = ldrstall;
      FlushD = pc_wr_pending | PCSrcW | BranchTakenE;
      FlushE = ldrstall | BranchTakenE;
      FlushW = (state == ABORT);
    end
    FlagWrEnE = ~StallE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      wcnt       <= '0;
      MemTimeout <= 1'b0;
      StallCount <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (state == ABORT) MemTimeout <= 1'b1;
      if (StallF && (StallCount != {CW{1'b1}})) StallCount <= StallCount + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random checks of hazard_ctrl against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CW      = 4;
  localparam int CMAX    = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic RegWriteM, RegWriteW, MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic FlagWrEnE, MemTimeout;
  logic [CW-1:0] StallCount;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: consecutive stalled cycles of the current access, abort pending, sticky timeout, counter
  int m_wait  = 0;
  bit m_abort = 1'b0;
  bit m_to    = 1'b0;
  int m_cnt   = 0;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .FlagWrEnE(FlagWrEnE), .MemTimeout(MemTimeout), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = '0;
    {RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
    {MemReqM, MemReadyM} = '0;
  endtask

  // one cycle: check combinational outputs mid-cycle, then advance the model on the edge
  task automatic step();
    int  fa, fb;
    bit  ldr, pcw, ms;
    bit  sf, sd, se, sm, fd, fe, fw;
    @(negedge clk);
    fa  = (Match_1E_M && RegWriteM) ? 2 : (Match_1E_W && RegWriteW) ? 1 : 0;
    fb  = (Match_2E_M && RegWriteM) ? 2 : (Match_2E_W && RegWriteW) ? 1 : 0;
    ldr = Match_12D_E && MemtoRegE;
    pcw = PCSrcD || PCSrcE || PCSrcM;
    ms  = !m_abort && MemReqM && !MemReadyM;
    if (ms) begin
      {sf, sd, se, sm} = 4'b1111;
      {fd, fe, fw}     = 3'b001;
    end else begin
      sf = ldr || pcw;
      sd = ldr;
      se = 1'b0;
      sm = 1'b0;
      fd = pcw || PCSrcW || BranchTakenE;
      fe = ldr || BranchTakenE;
      fw = m_abort;
    end
    chk("fwdA",    int'(ForwardAE), fa);
    chk("fwdB",    int'(ForwardBE), fb);
    chk("stalls",  int'({StallF, StallD, StallE, StallM}), int'({sf, sd, se, sm}));
    chk("flushes", int'({FlushD, FlushE, FlushW}), int'({fd, fe, fw}));
    chk("flagwr",  int'(FlagWrEnE), int'(!se));
    chk("timeout", int'(MemTimeout), int'(m_to));
    chk("stcnt",   int'(StallCount), m_cnt);
    @(posedge clk);
    if (!reset) begin
      m_wait = 0; m_abort = 1'b0; m_to = 1'b0; m_cnt = 0;
    end else begin
      if (m_abort) begin
        m_abort = 1'b0; m_to = 1'b1; m_wait = 0;
      end else if (ms) begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_abort = 1'b1; m_wait = 0;
        end
      end else begin
        m_wait = 0;
      end
      if (sf && m_cnt < CMAX) m_cnt++;
    end
    #1;
  endtask

  initial begin
    clear_in();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_timeout", int'(MemTimeout), 0);
    chk("rst_stcnt",   int'(StallCount), 0);
    step();

    // forwarding priority, both sources
    {Match_1E_M, Match_1E_W, RegWriteM, RegWriteW} = 4'b1111;
    step();
    chk("fwdA_M", int'(ForwardAE), 2);
    RegWriteM = 1'b0;
    step();
    chk("fwdA_W", int'(ForwardAE), 1);
    clear_in();
    {Match_2E_M, Match_2E_W, RegWriteM, RegWriteW} = 4'b1111;
    step();
    RegWriteM = 1'b0;
    step();
    chk("fwdB_W", int'(ForwardBE), 1);

    // load-use
    clear_in();
    {MemtoRegE, Match_12D_E} = 2'b11;
    step();
    clear_in();
    step();
    chk("ldr_cnt", int'(StallCount), 1);

    // branch and PC write
    BranchTakenE = 1'b1;
    step();
    clear_in();
    PCSrcD = 1'b1;
    step();
    clear_in();

    // 3-cycle memory wait with a concurrent branch
    reset = 1'b0; step(); reset = 1'b1;
    {MemReqM, MemReadyM, BranchTakenE} = 3'b101;
    repeat (3) step();
    chk("wait_cnt", int'(StallCount), 3);
    MemReadyM = 1'b1;
    step();
    clear_in();
    step();

    // never-ready access: full timeout then abort
    reset = 1'b0; step(); reset = 1'b1;
    MemReqM = 1'b1;
    repeat (TIMEOUT) step();
    chk("to_abort_flushw", int'(FlushW), 1);
    chk("to_abort_stall",  int'(StallF), 0);
    step();
    clear_in();
    chk("to_sticky", int'(MemTimeout), 1);
    step();

    // ready on the last wait cycle: no timeout
    reset = 1'b0; step(); reset = 1'b1;
    MemReqM = 1'b1;
    repeat (TIMEOUT - 1) step();
    MemReadyM = 1'b1;
    step();
    clear_in();
    step();
    chk("late_ready_to", int'(MemTimeout), 0);

    // reset during a wait
    MemReqM = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_cnt", int'(StallCount), 0);
    chk("midrst_to",  int'(MemTimeout), 0);
    step();
    clear_in();
    step();

    // counter saturation
    reset = 1'b0; step(); reset = 1'b1;
    PCSrcD = 1'b1;
    repeat (20) step();
    clear_in();
    chk("sat_cnt", int'(StallCount), CMAX);
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = 5'($urandom);
      {RegWriteM, RegWriteW, MemtoRegE} = 3'($urandom);
      PCSrcD       = ($urandom_range(0, 7) == 0);
      PCSrcE       = ($urandom_range(0, 7) == 0);
      PCSrcM       = ($urandom_range(0, 7) == 0);
      PCSrcW       = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 5) == 0);
      MemReqM      = ($urandom_range(0, 15) != 0);
      MemReadyM    = ($urandom_range(0, 9) < ((i % 400 < 100) ? 0 : 4));
      reset        = ($urandom_range(0, 299) != 0);
      step();
    end
    reset = 1'b1;
    clear_in();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
